// File: rtl/spififo_pkg.sv
// Shared definitions for the SPI peripheral with TX/RX FIFOs: controller
// state encoding and the FIFO occupancy-count width.
package spififo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  // An occupancy count must reach DEPTH itself, hence the extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an exact occupancy count.
// A write into a full FIFO is accepted when a read happens in the same cycle.
module sync_fifo
  import spififo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_rd_en  = rd_ready && !w_empty;
  assign w_wr_en  = wr_valid && (!w_full || w_rd_en);
  assign wr_ready = !w_full;
  assign rd_valid = !w_empty;
  assign rd_data  = r_mem[r_rd_ptr];
  assign level    = r_level;

  // Storage is not reset: clearing the pointers is enough to discard it.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spi_fifo_peripheral.sv
// SPI peripheral: oversampled SPI pins feed a shift engine that pops words
// from a TX FIFO onto cipo and pushes words assembled from copi into an RX FIFO.
module spi_fifo_peripheral
  import spififo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CPOL  = 0,
  parameter int CPHA  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclk,
  input  logic                          copi,
  input  logic                          csn,
  output logic                          cipo,
  input  logic [WIDTH-1:0]              tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [WIDTH-1:0]              rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [level_width(DEPTH)-1:0] tx_level,
  output logic [level_width(DEPTH)-1:0] rx_level,
  output logic                          tx_underflow,
  output logic                          rx_overflow,
  input  logic                          flag_clear
);

  localparam int   CW     = $clog2(WIDTH) + 1;
  localparam logic L_CPOL = (CPOL != 0);
  localparam logic L_CPHA = (CPHA != 0);

  logic [1:0]       r_sclk_sync, r_copi_sync, r_csn_sync;
  logic             r_sclk_prev, r_csn_prev, r_copi_d;
  logic             r_lead_pulse, r_trail_pulse, r_csn_fall, r_csn_rise;
  spi_state_t       r_state;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-2:0] r_rx_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_cipo, r_tx_underflow, r_rx_overflow;

  logic             w_sample, w_shift, w_last_bit;
  logic             w_rx_push, w_rx_not_full, w_rx_drop;
  logic [WIDTH-1:0] w_rx_word, w_tx_head, w_tx_load;
  logic             w_tx_valid, w_tx_pop;

  // Edge pulses are registered so copi (delayed to match) is stable when used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync   <= {2{L_CPOL}};
      r_copi_sync   <= 2'b00;
      r_csn_sync    <= 2'b11;
      r_sclk_prev   <= L_CPOL;
      r_csn_prev    <= 1'b1;
      r_copi_d      <= 1'b0;
      r_lead_pulse  <= 1'b0;
      r_trail_pulse <= 1'b0;
      r_csn_fall    <= 1'b0;
      r_csn_rise    <= 1'b0;
    end else begin
      r_sclk_sync   <= {r_sclk_sync[0], sclk};
      r_copi_sync   <= {r_copi_sync[0], copi};
      r_csn_sync    <= {r_csn_sync[0], csn};
      r_sclk_prev   <= r_sclk_sync[1];
      r_csn_prev    <= r_csn_sync[1];
      r_copi_d      <= r_copi_sync[1];
      r_lead_pulse  <= (r_sclk_sync[1] ^ L_CPOL) & ~(r_sclk_prev ^ L_CPOL);
      r_trail_pulse <= ~(r_sclk_sync[1] ^ L_CPOL) & (r_sclk_prev ^ L_CPOL);
      r_csn_fall    <= ~r_csn_sync[1] & r_csn_prev;
      r_csn_rise    <= r_csn_sync[1] & ~r_csn_prev;
    end
  end

  assign w_sample   = L_CPHA ? r_trail_pulse : r_lead_pulse;
  assign w_shift    = L_CPHA ? r_lead_pulse : r_trail_pulse;
  assign w_last_bit = (r_bit_cnt == CW'(WIDTH - 1));
  assign w_rx_word  = {r_rx_shift, r_copi_d};
  assign w_rx_push  = (r_state == SHIFT) && w_sample && w_last_bit;
  assign w_rx_drop  = w_rx_push && !w_rx_not_full && !(rx_valid && rx_ready);
  assign w_tx_pop   = (r_state == LOAD);
  assign w_tx_load  = w_tx_valid ? w_tx_head : '0;
  assign cipo       = r_cipo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_cipo     <= 1'b0;
    end else if (r_csn_rise) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_cipo    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cipo    <= 1'b0;
          r_bit_cnt <= '0;
          if (r_csn_fall) r_state <= LOAD;
        end
        LOAD: begin
          // CPHA=0 needs the MSB on the pin before the first (leading) sample.
          r_bit_cnt  <= '0;
          r_tx_shift <= L_CPHA ? w_tx_load : (w_tx_load << 1);
          if (!L_CPHA) r_cipo <= w_tx_load[WIDTH-1];
          r_state    <= SHIFT;
        end
        SHIFT: begin
          if (w_sample) begin
            r_rx_shift <= w_rx_word[WIDTH-2:0];
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              r_state   <= LOAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_shift && (L_CPHA || r_bit_cnt != '0)) begin
            // With CPHA=0 the trailing edge after the last bit belongs to the
            // previous word; the new MSB was already presented by LOAD.
            r_cipo     <= r_tx_shift[WIDTH-1];
            r_tx_shift <= r_tx_shift << 1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A new error in the same cycle as flag_clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_underflow <= 1'b0;
      r_rx_overflow  <= 1'b0;
    end else begin
      if (flag_clear) begin
        r_tx_underflow <= 1'b0;
        r_rx_overflow  <= 1'b0;
      end
      if (w_tx_pop && !w_tx_valid) r_tx_underflow <= 1'b1;
      if (w_rx_drop)               r_rx_overflow  <= 1'b1;
    end
  end

  assign tx_underflow = r_tx_underflow;
  assign rx_overflow  = r_rx_overflow;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (tx_data),
    .wr_valid (tx_valid),
    .wr_ready (tx_ready),
    .rd_data  (w_tx_head),
    .rd_valid (w_tx_valid),
    .rd_ready (w_tx_pop),
    .level    (tx_level)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (w_rx_word),
    .wr_valid (w_rx_push),
    .wr_ready (w_rx_not_full),
    .rd_data  (rx_data),
    .rd_valid (rx_valid),
    .rd_ready (rx_ready),
    .level    (rx_level)
  );

endmodule

// File: tb/tb_spi_fifo_peripheral.sv
// Directed bench: four peripherals (one per SPI mode, DEPTH=4) driven by a
// bit-banged SPI controller and a host-side FIFO driver.
module tb_spi_fifo_peripheral;

  localparam int H = 5;  // sclk half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        copi, flag_clear;
  logic [15:0] tx_data;
  logic [3:0]  sclk_v, csn_v, cipo_v, tx_valid_v, tx_ready_v;
  logic [3:0]  rx_valid_v, rx_ready_v, tx_underflow_v, rx_overflow_v;
  logic [15:0] rx_data_v  [4];
  logic [2:0]  tx_level_v [4];
  logic [2:0]  rx_level_v [4];
  logic [15:0] tb_mo [5];
  logic [15:0] tb_mi [5];
  int n_cmp  = 0;
  int n_fail = 0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    spi_fifo_peripheral #(.WIDTH(16), .DEPTH(4), .CPOL(gi / 2), .CPHA(gi % 2)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .sclk         (sclk_v[gi]),
      .copi         (copi),
      .csn          (csn_v[gi]),
      .cipo         (cipo_v[gi]),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid_v[gi]),
      .tx_ready     (tx_ready_v[gi]),
      .rx_data      (rx_data_v[gi]),
      .rx_valid     (rx_valid_v[gi]),
      .rx_ready     (rx_ready_v[gi]),
      .tx_level     (tx_level_v[gi]),
      .rx_level     (rx_level_v[gi]),
      .tx_underflow (tx_underflow_v[gi]),
      .rx_overflow  (rx_overflow_v[gi]),
      .flag_clear   (flag_clear)
    );
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clear();
    flag_clear = 1'b1;
    @(negedge clk);
    flag_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic host_push(input int m, input logic [15:0] d);
    int t = 0;
    while (tx_ready_v[m] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_wait: tx_ready=%b required 1", tx_ready_v[m]);
    end
    tx_data       = d;
    tx_valid_v[m] = 1'b1;
    @(negedge clk);
    tx_valid_v[m] = 1'b0;
  endtask

  task automatic host_pop(input int m, output logic [15:0] d, output logic v);
    v             = rx_valid_v[m];
    d             = rx_data_v[m];
    rx_ready_v[m] = 1'b1;
    @(negedge clk);
    rx_ready_v[m] = 1'b0;
  endtask

  task automatic spi_start(input int m);
    csn_v[m] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic spi_stop(input int m);
    repeat (H) @(negedge clk);
    csn_v[m] = 1'b1;
    copi     = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // One word (or its first nbits) MSB first; cipo captured at the sample edge.
  task automatic spi_word(input int m, input int idx, input int nbits, input bit lat_chk);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    tb_mi[idx] = '0;
    for (int b = 15; b >= 16 - nbits; b--) begin
      if (!cpha) begin
        copi = tb_mo[idx][b];
        repeat (H) @(negedge clk);
        sclk_v[m] = ~cpol;
        tb_mi[idx][b] = cipo_v[m];
        if (lat_chk && b == 0) begin
          repeat (3) @(negedge clk);
          n_cmp++;
          if (rx_valid_v[m] !== 1'b0)
            $display("FAIL rx_valid_early: got %b required 0", rx_valid_v[m]);
          if (rx_valid_v[m] !== 1'b0) n_fail++;
          @(negedge clk);
          n_cmp++;
          if (rx_valid_v[m] !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_valid_latency: got %b required 1", rx_valid_v[m]);
          end
          repeat (H - 4) @(negedge clk);
        end else begin
          repeat (H) @(negedge clk);
        end
        sclk_v[m] = cpol;
      end else begin
        sclk_v[m] = ~cpol;
        copi = tb_mo[idx][b];
        repeat (H) @(negedge clk);
        sclk_v[m] = cpol;
        tb_mi[idx][b] = cipo_v[m];
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic spi_frame(input int m, input int n, input bit lat_chk);
    spi_start(m);
    for (int i = 0; i < n; i++) spi_word(m, i, 16, lat_chk && (i == n - 1));
    spi_stop(m);
  endtask

  task automatic test_reset();
    do_reset();
    for (int m = 0; m < 4; m++) begin
      n_cmp++;
      if (tx_level_v[m] !== 3'd0 || rx_level_v[m] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_levels m%0d: tx=%0d rx=%0d required 0 0", m, tx_level_v[m], rx_level_v[m]);
      end
      n_cmp++;
      if (tx_ready_v[m] !== 1'b1 || rx_valid_v[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_handshake m%0d: tx_ready=%b rx_valid=%b required 1 0", m, tx_ready_v[m], rx_valid_v[m]);
      end
      n_cmp++;
      if (cipo_v[m] !== 1'b0 || tx_underflow_v[m] !== 1'b0 || rx_overflow_v[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs m%0d: cipo=%b unf=%b ovf=%b required 0 0 0", m, cipo_v[m], tx_underflow_v[m], rx_overflow_v[m]);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] d;
    logic v;
    host_push(0, 16'hA503);
    n_cmp++;
    if (tx_level_v[0] !== 3'd1) begin
      n_fail++;
      $display("FAIL basic_tx_level: got %0d required 1", tx_level_v[0]);
    end
    tb_mo[0] = 16'h3C5A;
    spi_frame(0, 1, 1'b1);
    n_cmp++;
    if (tb_mi[0] !== 16'hA503) begin
      n_fail++;
      $display("FAIL basic_cipo: got %h required a503", tb_mi[0]);
    end
    n_cmp++;
    if (rx_level_v[0] !== 3'd1 || rx_data_v[0] !== 16'h3C5A) begin
      n_fail++;
      $display("FAIL basic_rx: level=%0d data=%h required 1 3c5a", rx_level_v[0], rx_data_v[0]);
    end
    host_pop(0, d, v);
    n_cmp++;
    if (rx_valid_v[0] !== 1'b0 || tx_level_v[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_drained: rx_valid=%b tx_level=%0d required 0 0", rx_valid_v[0], tx_level_v[0]);
    end
  endtask

  task automatic test_modes();
    logic [15:0] tx_tab [4];
    logic [15:0] rx_tab [4];
    logic [15:0] d;
    logic v;
    tx_tab = '{16'h8001, 16'h7FFE, 16'hC3A5, 16'h0F0F};
    rx_tab = '{16'h55AA, 16'hA55A, 16'h0001, 16'hFFFF};
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 4; i++) host_push(m, tx_tab[i] ^ 16'(m << 8));
      n_cmp++;
      if (tx_ready_v[m] !== 1'b0 || tx_level_v[m] !== 3'd4) begin
        n_fail++;
        $display("FAIL mode%0d_tx_full: ready=%b level=%0d required 0 4", m, tx_ready_v[m], tx_level_v[m]);
      end
      for (int i = 0; i < 4; i++) tb_mo[i] = rx_tab[i] ^ 16'(m);
      spi_frame(m, 4, 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (tb_mi[i] !== (tx_tab[i] ^ 16'(m << 8))) begin
          n_fail++;
          $display("FAIL mode%0d_cipo_w%0d: got %h required %h", m, i, tb_mi[i], tx_tab[i] ^ 16'(m << 8));
        end
      end
      n_cmp++;
      if (rx_level_v[m] !== 3'd4) begin
        n_fail++;
        $display("FAIL mode%0d_rx_level: got %0d required 4", m, rx_level_v[m]);
      end
      for (int i = 0; i < 4; i++) begin
        host_pop(m, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== (rx_tab[i] ^ 16'(m))) begin
          n_fail++;
          $display("FAIL mode%0d_rx_w%0d: valid=%b data=%h required 1 %h", m, i, v, d, rx_tab[i] ^ 16'(m));
        end
      end
    end
  endtask

  task automatic test_underflow();
    logic [15:0] d;
    logic v;
    pulse_clear();
    n_cmp++;
    if (tx_underflow_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL unf_cleared_before: got %b required 0", tx_underflow_v[0]);
    end
    tb_mo[0] = 16'h1357;
    tb_mo[1] = 16'h2468;
    spi_frame(0, 2, 1'b0);
    n_cmp++;
    if (tb_mi[0] !== 16'h0000 || tb_mi[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL unf_cipo_zero: got %h %h required 0000 0000", tb_mi[0], tb_mi[1]);
    end
    n_cmp++;
    if (tx_underflow_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL unf_flag_set: got %b required 1", tx_underflow_v[0]);
    end
    pulse_clear();
    n_cmp++;
    if (tx_underflow_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL unf_flag_clear: got %b required 0", tx_underflow_v[0]);
    end
    host_pop(0, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== 16'h1357) begin
      n_fail++;
      $display("FAIL unf_rx_w0: valid=%b data=%h required 1 1357", v, d);
    end
    host_pop(0, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== 16'h2468) begin
      n_fail++;
      $display("FAIL unf_rx_w1: valid=%b data=%h required 1 2468", v, d);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    logic v;
    logic [15:0] exp_tab [4];
    exp_tab = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    pulse_clear();
    tb_mo = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    spi_frame(1, 5, 1'b0);
    n_cmp++;
    if (rx_level_v[1] !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_rx_level: got %0d required 4", rx_level_v[1]);
    end
    n_cmp++;
    if (rx_overflow_v[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: got %b required 1", rx_overflow_v[1]);
    end
    for (int i = 0; i < 4; i++) begin
      host_pop(1, d, v);
      n_cmp++;
      if (v !== 1'b1 || d !== exp_tab[i]) begin
        n_fail++;
        $display("FAIL ovf_rx_w%0d: valid=%b data=%h required 1 %h", i, v, d, exp_tab[i]);
      end
    end
    n_cmp++;
    if (rx_valid_v[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drained: rx_valid=%b required 0", rx_valid_v[1]);
    end
  endtask

  task automatic test_abort();
    logic [15:0] d;
    logic v;
    pulse_clear();
    host_push(0, 16'h1111);
    host_push(0, 16'h2222);
    host_push(0, 16'h3333);
    tb_mo[0] = 16'hBEEF;
    spi_start(0);
    spi_word(0, 0, 7, 1'b0);
    spi_stop(0);
    n_cmp++;
    if (rx_level_v[0] !== 3'd0 || tx_level_v[0] !== 3'd2) begin
      n_fail++;
      $display("FAIL abort_levels: rx=%0d tx=%0d required 0 2", rx_level_v[0], tx_level_v[0]);
    end
    tb_mo[0] = 16'h1234;
    spi_frame(0, 1, 1'b0);
    n_cmp++;
    if (tb_mi[0] !== 16'h2222) begin
      n_fail++;
      $display("FAIL abort_cipo: got %h required 2222", tb_mi[0]);
    end
    n_cmp++;
    if (rx_level_v[0] !== 3'd1 || rx_data_v[0] !== 16'h1234) begin
      n_fail++;
      $display("FAIL abort_rx: level=%0d data=%h required 1 1234", rx_level_v[0], rx_data_v[0]);
    end
    n_cmp++;
    if (tx_underflow_v[0] !== 1'b0 || rx_overflow_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flags: unf=%b ovf=%b required 0 0", tx_underflow_v[0], rx_overflow_v[0]);
    end
    host_pop(0, d, v);
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    logic v;
    host_push(0, 16'hCAFE);
    host_push(0, 16'hBABE);
    host_push(0, 16'hD00D);
    n_cmp++;
    if (tx_level_v[0] !== 3'd3) begin
      n_fail++;
      $display("FAIL rstmid_tx_queued: got %0d required 3", tx_level_v[0]);
    end
    tb_mo[0] = 16'hFFFF;
    spi_start(0);
    spi_word(0, 0, 5, 1'b0);
    rst       = 1'b1;
    csn_v[0]  = 1'b1;
    sclk_v[0] = 1'b0;
    copi      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (tx_level_v[0] !== 3'd0 || rx_level_v[0] !== 3'd0 || cipo_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state: tx=%0d rx=%0d cipo=%b required 0 0 0", tx_level_v[0], rx_level_v[0], cipo_v[0]);
    end
    tb_mo[0] = 16'h0F0F;
    spi_frame(0, 1, 1'b0);
    n_cmp++;
    if (tb_mi[0] !== 16'h0000 || tx_underflow_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_next_frame: cipo=%h unf=%b required 0000 1", tb_mi[0], tx_underflow_v[0]);
    end
    host_pop(0, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL rstmid_rx: valid=%b data=%h required 1 0f0f", v, d);
    end
  endtask

  initial begin
    rst        = 1'b1;
    sclk_v     = 4'b1100;
    csn_v      = 4'hF;
    copi       = 1'b0;
    tx_data    = '0;
    tx_valid_v = '0;
    rx_ready_v = '0;
    flag_clear = 1'b0;
    test_reset();
    test_basic();
    test_modes();
    test_underflow();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_fifo_peripheral.md
SPI_FIFO_PERIPHERAL -- requirements
Module: spi_fifo_peripheral

Interface
REQ-001 Parameter WIDTH, default 16, bits per SPI word (8..32).
REQ-002 Parameter DEPTH, default 16, entries per FIFO, power of two, >=2.
REQ-003 Parameter CPOL, default 0, SCLK idle level.
REQ-004 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 sclk, copi, csn  in  1 each  SPI pins, asynchronous to clk, csn active-low.
REQ-008 cipo  out  1  SPI data out; 0 while csn is high.
REQ-009 tx_data  in  WIDTH; tx_valid  in  1; tx_ready  out  1  TX FIFO write port, valid/ready handshake.
REQ-010 rx_data  out  WIDTH; rx_valid  out  1; rx_ready  in  1  RX FIFO read port, valid/ready handshake.
REQ-011 tx_level, rx_level  out  $clog2(DEPTH)+1  occupancy counts.
REQ-012 tx_underflow, rx_overflow  out  1  sticky error flags; flag_clear  in  1  clears both.

Function
REQ-013 sclk, copi and csn SHALL each pass a 2-flop synchronizer; edges SHALL be detected one cycle later (pin-to-detect = 3 clk); clk SHALL be >= 6x sclk.
REQ-014 Sample edge = rising edge of (sclk XOR CPOL) when CPHA=0, falling edge when CPHA=1; shift edge is the opposite edge.
REQ-015 Bits SHALL be MSB first on both copi and cipo.
REQ-016 States: IDLE (csn high), LOAD, SHIFT; IDLE->LOAD on detected csn fall; LOAD->SHIFT after one cycle; SHIFT->LOAD after the WIDTH-th sample edge; any state->IDLE on detected csn rise.
REQ-017 LOAD SHALL pop the TX FIFO head into the shift register; if empty, load all-zeros and set tx_underflow.
REQ-018 With CPHA=0 the MSB SHALL be on cipo before the first sample edge; with CPHA=1 on the first shift edge; subsequent bits change on shift edges only.
REQ-019 On the WIDTH-th sample edge the assembled word SHALL be written to the RX FIFO in the detect cycle; rx_valid high the following cycle.
REQ-020 RX FIFO full at word completion: word dropped, rx_overflow set, stored contents unchanged.
REQ-021 csn rising mid-word: partial RX bits discarded, bit counter cleared, popped TX word lost (not re-queued), no flags set.
REQ-022 tx_ready = TX FIFO not full; simultaneous host write and LOAD pop on a full FIFO SHALL both occur, level unchanged.
REQ-023 Simultaneous host read and word completion on a full RX FIFO SHALL both occur; no overflow.
REQ-024 Level counters SHALL be exact at all times, including wrap of read/write pointers past DEPTH-1.
REQ-025 flag_clear coinciding with a new error event: error wins, flag stays set.
REQ-026 rx_data SHALL present the head entry whenever rx_valid is high (first-word fall-through).

Reset
REQ-027 rst asserted: state IDLE, FIFOs empty, levels 0, cipo 0, tx_ready 1, rx_valid 0, flags 0, synchronizers loaded with csn=1, sclk=CPOL, copi=0.
REQ-028 rst asserted mid-transfer: all buffered data discarded; after release the block waits for a fresh csn fall.

Structure
REQ-029 Shared package spififo_pkg SHALL hold the state encoding (IDLE, LOAD, SHIFT) and the level-width function.
REQ-030 One sub-module sync_fifo (WIDTH, DEPTH, FWFT, level output) SHALL be instantiated twice, TX and RX.

Verification
REQ-031 Mode 0, WIDTH=16: host writes 16'hA503; controller sends 16'h3C5A -> cipo shifts A503 MSB first, rx_data=16'h3C5A, rx_valid 3-4 clk after last sample edge.
REQ-032 All four CPOL/CPHA combinations, 4 back-to-back words in one csn frame -> all words echoed and received intact, in order.
REQ-033 TX FIFO empty, controller clocks 2 words -> cipo all zeros, tx_underflow=1; flag_clear -> 0.
REQ-034 DEPTH=4, controller sends 5 words with no host reads -> rx_level=4, rx_overflow=1, first 4 words retained.
REQ-035 csn raised after 7 bits, then full 16'h1234 word -> only 16'h1234 in RX FIFO, rx_level=1.
REQ-036 rst pulsed mid-word with 3 TX entries queued -> levels 0, cipo 0, next frame returns zeros with tx_underflow=1.
